// File: rtl/cache_pkg.sv
// Shared definitions for the banked cache data array: default geometry,
// FSM state encodings and width helpers.
package cache_pkg;

    localparam int DEF_SETS       = 16;
    localparam int DEF_WAYS       = 2;
    localparam int DEF_LINE_BYTES = 32;
    localparam int DEF_BEAT_BYTES = 8;

    typedef logic [1:0] state_t;

    localparam state_t ST_INIT = 2'd0;
    localparam state_t ST_IDLE = 2'd1;
    localparam state_t ST_FILL = 2'd2;

    // Index width for a power-of-two count, never narrower than one bit so
    // that single-entry dimensions still get a usable select signal.
    function automatic int log2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/cache_data_banked_if.sv
// Request/response bundle between the cache controller / refill path
// (master) and the banked data array (slave).
interface cache_data_banked_if
    import cache_pkg::*;
#(
    parameter int SETS       = DEF_SETS,
    parameter int WAYS       = DEF_WAYS,
    parameter int LINE_BYTES = DEF_LINE_BYTES,
    parameter int BEAT_BYTES = DEF_BEAT_BYTES
);

    localparam int IDX_W     = log2_min1(SETS);
    localparam int WAY_W     = log2_min1(WAYS);
    localparam int LINE_BITS = 8 * LINE_BYTES;
    localparam int BEAT_BITS = 8 * BEAT_BYTES;

    logic                      ready_o;
    logic                      rd_req_i;
    logic [IDX_W-1:0]          rd_index_i;
    logic [WAYS*LINE_BITS-1:0] rd_data_o;
    logic                      rd_valid_o;
    logic                      wr_req_i;
    logic [IDX_W-1:0]          wr_index_i;
    logic [WAY_W-1:0]          wr_way_i;
    logic [LINE_BYTES-1:0]     wr_be_i;
    logic [LINE_BITS-1:0]      wr_data_i;
    logic                      fill_start_i;
    logic [IDX_W-1:0]          fill_index_i;
    logic [WAY_W-1:0]          fill_way_i;
    logic                      fill_beat_valid_i;
    logic [BEAT_BITS-1:0]      fill_beat_data_i;
    logic                      fill_beat_ready_o;
    logic                      fill_done_o;

    modport master (
        input  ready_o, rd_data_o, rd_valid_o, fill_beat_ready_o, fill_done_o,
        output rd_req_i, rd_index_i, wr_req_i, wr_index_i, wr_way_i, wr_be_i,
               wr_data_i, fill_start_i, fill_index_i, fill_way_i,
               fill_beat_valid_i, fill_beat_data_i
    );

    modport slave (
        output ready_o, rd_data_o, rd_valid_o, fill_beat_ready_o, fill_done_o,
        input  rd_req_i, rd_index_i, wr_req_i, wr_index_i, wr_way_i, wr_be_i,
               wr_data_i, fill_start_i, fill_index_i, fill_way_i,
               fill_beat_valid_i, fill_beat_data_i
    );

endinterface

// File: rtl/cache_data_way.sv
// One way of the data array: SETS lines, asynchronous read, synchronous
// byte-enabled write. Contents are not reset; the top sweeps zeros in.
module cache_data_way
    import cache_pkg::*;
#(
    parameter int SETS       = DEF_SETS,
    parameter int LINE_BYTES = DEF_LINE_BYTES,
    parameter int IDX_W      = log2_min1(SETS),
    parameter int LINE_BITS  = 8 * LINE_BYTES
)(
    input  logic                  clk_i,
    input  logic                  wr_en,
    input  logic [IDX_W-1:0]      wr_index,
    input  logic [LINE_BYTES-1:0] wr_be,
    input  logic [LINE_BITS-1:0]  wr_data,
    input  logic [IDX_W-1:0]      rd_index,
    output logic [LINE_BITS-1:0]  rd_data
);

    logic [LINE_BITS-1:0] mem [SETS];

    // Update only the bytes whose enable is set.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            for (int b = 0; b < LINE_BYTES; b++) begin
                if (wr_be[b]) begin
                    mem[wr_index][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    assign rd_data = mem[rd_index];

endmodule

// File: rtl/cache_data_banked.sv
// N-way set-associative cache data array with byte-masked writes, a
// registered write-first read port, a beat-wise refill engine and a
// post-reset zeroing sweep.
module cache_data_banked
    import cache_pkg::*;
#(
    parameter int SETS       = DEF_SETS,
    parameter int WAYS       = DEF_WAYS,
    parameter int LINE_BYTES = DEF_LINE_BYTES,
    parameter int BEAT_BYTES = DEF_BEAT_BYTES
)(
    input  logic              clk_i,
    input  logic              rst_n_i,
    cache_data_banked_if.slave bus
);

    localparam int IDX_W     = log2_min1(SETS);
    localparam int WAY_W     = log2_min1(WAYS);
    localparam int LINE_BITS = 8 * LINE_BYTES;
    localparam int BEATS     = LINE_BYTES / BEAT_BYTES;
    localparam int BEAT_W    = log2_min1(BEATS);

    state_t                    state;
    logic [IDX_W-1:0]          set_cnt;
    logic [BEAT_W-1:0]         beat_cnt;
    logic [IDX_W-1:0]          fill_index;
    logic [WAY_W-1:0]          fill_way;
    logic                      fill_done_q;
    logic                      rd_valid_q;
    logic [WAYS*LINE_BITS-1:0] rd_data_q;

    logic [WAYS-1:0]           way_we;
    logic [IDX_W-1:0]          wr_index;
    logic [LINE_BYTES-1:0]     wr_be;
    logic [LINE_BITS-1:0]      wr_data;
    logic [LINE_BITS-1:0]      way_rd [WAYS];
    logic [WAYS*LINE_BITS-1:0] rd_next;

    logic rd_accept;
    logic wr_accept;
    logic fill_accept;
    logic beat_accept;
    logic last_beat;

    assign rd_accept   = bus.rd_req_i && ((state == ST_IDLE) || (state == ST_FILL));
    assign wr_accept   = bus.wr_req_i && (state == ST_IDLE);
    assign fill_accept = bus.fill_start_i && (state == ST_IDLE);
    assign beat_accept = bus.fill_beat_valid_i && (state == ST_FILL);
    assign last_beat   = beat_accept && (beat_cnt == BEAT_W'(BEATS - 1));

    // Single shared write port: the zeroing sweep, a controller write and a
    // refill beat are mutually exclusive by state, so one mux feeds all ways.
    always_comb begin
        way_we   = '0;
        wr_index = bus.wr_index_i;
        wr_be    = bus.wr_be_i;
        wr_data  = bus.wr_data_i;
        case (state)
            ST_INIT: begin
                way_we   = '1;
                wr_index = set_cnt;
                wr_be    = '1;
                wr_data  = '0;
            end
            ST_IDLE: begin
                for (int w = 0; w < WAYS; w++) begin
                    way_we[w] = wr_accept && (bus.wr_way_i == WAY_W'(w));
                end
            end
            ST_FILL: begin
                wr_index = fill_index;
                wr_data  = {BEATS{bus.fill_beat_data_i}};
                for (int b = 0; b < LINE_BYTES; b++) begin
                    wr_be[b] = (BEAT_W'(b / BEAT_BYTES) == beat_cnt);
                end
                for (int w = 0; w < WAYS; w++) begin
                    way_we[w] = beat_accept && (fill_way == WAY_W'(w));
                end
            end
            default: ;
        endcase
    end

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        cache_data_way #(
            .SETS       (SETS),
            .LINE_BYTES (LINE_BYTES)
        ) u_way (
            .clk_i    (clk_i),
            .wr_en    (way_we[w]),
            .wr_index (wr_index),
            .wr_be    (wr_be),
            .wr_data  (wr_data),
            .rd_index (bus.rd_index_i),
            .rd_data  (way_rd[w])
        );
    end

    // Write-first bypass: bytes being written this cycle to the read set
    // replace the stale array contents for the written way.
    always_comb begin
        rd_next = '0;
        for (int w = 0; w < WAYS; w++) begin
            for (int b = 0; b < LINE_BYTES; b++) begin
                if (way_we[w] && (wr_index == bus.rd_index_i) && wr_be[b]) begin
                    rd_next[w*LINE_BITS + 8*b +: 8] = wr_data[8*b +: 8];
                end else begin
                    rd_next[w*LINE_BITS + 8*b +: 8] = way_rd[w][8*b +: 8];
                end
            end
        end
    end

    // Control FSM: zero sweep after reset, idle service, beat-wise refill.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state       <= ST_INIT;
            set_cnt     <= '0;
            beat_cnt    <= '0;
            fill_index  <= '0;
            fill_way    <= '0;
            fill_done_q <= 1'b0;
        end else begin
            fill_done_q <= 1'b0;
            case (state)
                ST_INIT: begin
                    set_cnt <= set_cnt + IDX_W'(1);
                    if (set_cnt == IDX_W'(SETS - 1)) begin
                        state <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (fill_accept) begin
                        fill_index <= bus.fill_index_i;
                        fill_way   <= bus.fill_way_i;
                        beat_cnt   <= '0;
                        state      <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (beat_accept) begin
                        beat_cnt <= beat_cnt + BEAT_W'(1);
                    end
                    if (last_beat) begin
                        fill_done_q <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end

    // Registered read port; data holds its last value between reads.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= rd_accept;
            if (rd_accept) begin
                rd_data_q <= rd_next;
            end
        end
    end

    assign bus.ready_o           = (state == ST_IDLE);
    assign bus.fill_beat_ready_o = (state == ST_FILL);
    assign bus.fill_done_o       = fill_done_q;
    assign bus.rd_valid_o        = rd_valid_q;
    assign bus.rd_data_o         = rd_data_q;

endmodule

// File: tb/tb_cache_data_banked.sv
// Self-checking bench for cache_data_banked: reference line model plus a
// queue of expected read results.
module tb_cache_data_banked;
    import cache_pkg::*;

    localparam int SETS       = 16;
    localparam int WAYS       = 2;
    localparam int LINE_BYTES = 32;
    localparam int BEAT_BYTES = 8;
    localparam int LINE_BITS  = 8 * LINE_BYTES;
    localparam int BEAT_BITS  = 8 * BEAT_BYTES;
    localparam int DATA_W     = WAYS * LINE_BITS;
    localparam int IDX_W      = 4;
    localparam int WAY_W      = 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int checks = 0;
    int fails  = 0;

    logic [LINE_BITS-1:0] model [SETS][WAYS];
    logic [DATA_W-1:0]    exp_q [$];

    cache_data_banked_if #(
        .SETS(SETS), .WAYS(WAYS), .LINE_BYTES(LINE_BYTES), .BEAT_BYTES(BEAT_BYTES)
    ) bus ();

    cache_data_banked #(
        .SETS(SETS), .WAYS(WAYS), .LINE_BYTES(LINE_BYTES), .BEAT_BYTES(BEAT_BYTES)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.rd_req_i          = 1'b0;
        bus.rd_index_i        = '0;
        bus.wr_req_i          = 1'b0;
        bus.wr_index_i        = '0;
        bus.wr_way_i          = '0;
        bus.wr_be_i           = '0;
        bus.wr_data_i         = '0;
        bus.fill_start_i      = 1'b0;
        bus.fill_index_i      = '0;
        bus.fill_way_i        = '0;
        bus.fill_beat_valid_i = 1'b0;
        bus.fill_beat_data_i  = '0;
    endtask

    task automatic model_clear();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++)
                model[s][w] = '0;
    endtask

    task automatic model_write(input int s, input int w,
                               input logic [LINE_BYTES-1:0] be,
                               input logic [LINE_BITS-1:0] d);
        for (int b = 0; b < LINE_BYTES; b++)
            if (be[b]) model[s][w][8*b +: 8] = d[8*b +: 8];
    endtask

    function automatic logic [DATA_W-1:0] model_set(input int s);
        logic [DATA_W-1:0] r;
        for (int w = 0; w < WAYS; w++) r[w*LINE_BITS +: LINE_BITS] = model[s][w];
        return r;
    endfunction

    // Drive a read and record what it must return.
    task automatic issue_read(input int s);
        bus.rd_req_i   = 1'b1;
        bus.rd_index_i = IDX_W'(s);
        exp_q.push_back(model_set(s));
    endtask

    task automatic drive_beat(input int s, input int w, input int k, input logic [7:0] val);
        logic [BEAT_BITS-1:0] bd;
        bd = {BEAT_BYTES{val}};
        bus.fill_beat_valid_i = 1'b1;
        bus.fill_beat_data_i  = bd;
        model[s][w][BEAT_BITS*k +: BEAT_BITS] = bd;
    endtask

    task automatic test_reset();
        int cycles;
        logic [DATA_W-1:0] got, exp, last_exp;
        idle_inputs();
        rst_n = 1'b0;
        repeat (3) step();
        checks++; if (bus.ready_o !== 1'b0) begin fails++; $display("[TB] FAIL reset_ready: got %b expected 0", bus.ready_o); end
        checks++; if (bus.rd_valid_o !== 1'b0) begin fails++; $display("[TB] FAIL reset_rd_valid: got %b expected 0", bus.rd_valid_o); end
        checks++; if (bus.rd_data_o !== '0) begin fails++; $display("[TB] FAIL reset_rd_data: got %h expected 0", bus.rd_data_o); end
        checks++; if (bus.fill_beat_ready_o !== 1'b0) begin fails++; $display("[TB] FAIL reset_beat_ready: got %b expected 0", bus.fill_beat_ready_o); end
        checks++; if (bus.fill_done_o !== 1'b0) begin fails++; $display("[TB] FAIL reset_fill_done: got %b expected 0", bus.fill_done_o); end
        model_clear();
        rst_n = 1'b1;
        cycles = 0;
        while (bus.ready_o !== 1'b1 && cycles < 64) begin
            step();
            cycles++;
        end
        checks++; if (cycles != SETS) begin fails++; $display("[TB] FAIL init_length: got %0d cycles expected %0d", cycles, SETS); end
        last_exp = '0;
        for (int s = 0; s < SETS; s++) begin
            issue_read(s);
            step();
            got = bus.rd_data_o;
            exp = exp_q.pop_front();
            last_exp = exp;
            checks++; if (bus.rd_valid_o !== 1'b1) begin fails++; $display("[TB] FAIL init_rd_valid set %0d: got %b expected 1", s, bus.rd_valid_o); end
            checks++; if (got !== exp) begin fails++; $display("[TB] FAIL init_read set %0d: got %h expected %h", s, got, exp); end
        end
        idle_inputs();
        step();
        checks++; if (bus.rd_valid_o !== 1'b0) begin fails++; $display("[TB] FAIL rd_valid_pulse: got %b expected 0", bus.rd_valid_o); end
        checks++; if (bus.rd_data_o !== last_exp) begin fails++; $display("[TB] FAIL rd_data_hold: got %h expected %h", bus.rd_data_o, last_exp); end
    endtask

    task automatic test_write_read();
        logic [DATA_W-1:0] got, exp;
        logic [LINE_BITS-1:0] d;
        d = {{28{8'hC3}}, 32'hDEADBEEF};
        bus.wr_req_i   = 1'b1;
        bus.wr_index_i = 4'd3;
        bus.wr_way_i   = 1'b1;
        bus.wr_be_i    = 32'h0000000F;
        bus.wr_data_i  = d;
        model_write(3, 1, 32'h0000000F, d);
        step();
        idle_inputs();
        issue_read(3);
        step();
        idle_inputs();
        got = bus.rd_data_o;
        exp = exp_q.pop_front();
        checks++; if (got !== exp) begin fails++; $display("[TB] FAIL write_read: got %h expected %h", got, exp); end
        checks++; if (got[LINE_BITS +: 32] !== 32'hDEADBEEF) begin fails++; $display("[TB] FAIL write_bytes: got %h expected deadbeef", got[LINE_BITS +: 32]); end
        checks++; if (got[LINE_BITS+32 +: LINE_BITS-32] !== '0) begin fails++; $display("[TB] FAIL write_mask: got %h expected 0", got[LINE_BITS+32 +: LINE_BITS-32]); end
        checks++; if (got[0 +: LINE_BITS] !== '0) begin fails++; $display("[TB] FAIL write_other_way: got %h expected 0", got[0 +: LINE_BITS]); end
    endtask

    task automatic test_bypass();
        logic [DATA_W-1:0] got, exp;
        logic [LINE_BITS-1:0] d;
        d = {8{32'hCAFEF00D}};
        bus.wr_req_i   = 1'b1;
        bus.wr_index_i = 4'd5;
        bus.wr_way_i   = 1'b0;
        bus.wr_be_i    = 32'hF0F000FF;
        bus.wr_data_i  = d;
        model_write(5, 0, 32'hF0F000FF, d);
        issue_read(5);
        step();
        got = bus.rd_data_o;
        exp = exp_q.pop_front();
        checks++; if (got !== exp) begin fails++; $display("[TB] FAIL bypass_same_set: got %h expected %h", got, exp); end
        checks++; if (got[7:0] !== 8'h0D) begin fails++; $display("[TB] FAIL bypass_byte0: got %h expected 0d", got[7:0]); end
        d = {16{16'h7E81}};
        bus.wr_index_i = 4'd6;
        bus.wr_way_i   = 1'b1;
        bus.wr_be_i    = 32'hFFFF0000;
        bus.wr_data_i  = d;
        model_write(6, 1, 32'hFFFF0000, d);
        issue_read(5);
        step();
        got = bus.rd_data_o;
        exp = exp_q.pop_front();
        checks++; if (got !== exp) begin fails++; $display("[TB] FAIL bypass_other_set: got %h expected %h", got, exp); end
        idle_inputs();
        issue_read(6);
        step();
        idle_inputs();
        got = bus.rd_data_o;
        exp = exp_q.pop_front();
        checks++; if (got !== exp) begin fails++; $display("[TB] FAIL back_to_back_set6: got %h expected %h", got, exp); end
    endtask

    task automatic test_fill();
        logic [DATA_W-1:0] got, exp;
        logic [LINE_BITS-1:0] d;
        bus.wr_req_i   = 1'b1;
        bus.wr_index_i = 4'd9;
        bus.wr_way_i   = 1'b0;
        bus.wr_be_i    = '1;
        bus.wr_data_i  = {LINE_BYTES{8'h5A}};
        model_write(9, 0, '1, {LINE_BYTES{8'h5A}});
        step();
        d = {{30{8'h00}}, 16'hBEEF};
        bus.wr_index_i   = 4'd2;
        bus.wr_be_i      = 32'h00000003;
        bus.wr_data_i    = d;
        model_write(2, 0, 32'h00000003, d);
        bus.fill_start_i = 1'b1;
        bus.fill_index_i = 4'd9;
        bus.fill_way_i   = 1'b0;
        step();
        idle_inputs();
        checks++; if (bus.fill_beat_ready_o !== 1'b1 || bus.ready_o !== 1'b0) begin fails++; $display("[TB] FAIL fill_entry: got beat_ready=%b ready=%b expected 1 0", bus.fill_beat_ready_o, bus.ready_o); end
        drive_beat(9, 0, 0, 8'h11);
        bus.wr_req_i   = 1'b1;
        bus.wr_index_i = 4'd7;
        bus.wr_way_i   = 1'b1;
        bus.wr_be_i    = '1;
        bus.wr_data_i  = '1;
        step();
        bus.wr_req_i = 1'b0;
        checks++; if (bus.fill_done_o !== 1'b0) begin fails++; $display("[TB] FAIL fill_done_early0: got %b expected 0", bus.fill_done_o); end
        drive_beat(9, 0, 1, 8'h22);
        step();
        checks++; if (bus.fill_done_o !== 1'b0) begin fails++; $display("[TB] FAIL fill_done_early1: got %b expected 0", bus.fill_done_o); end
        bus.fill_beat_valid_i = 1'b0;
        issue_read(9);
        step();
        bus.rd_req_i = 1'b0;
        got = bus.rd_data_o;
        exp = exp_q.pop_front();
        checks++; if (got !== exp) begin fails++; $display("[TB] FAIL read_mid_fill: got %h expected %h", got, exp); end
        checks++; if (got[128 +: 128] !== {16{8'h5A}}) begin fails++; $display("[TB] FAIL mid_fill_upper: got %h expected 5a bytes", got[128 +: 128]); end
        checks++; if (bus.fill_done_o !== 1'b0 || bus.fill_beat_ready_o !== 1'b1) begin fails++; $display("[TB] FAIL fill_gap: got done=%b beat_ready=%b expected 0 1", bus.fill_done_o, bus.fill_beat_ready_o); end
        drive_beat(9, 0, 2, 8'h33);
        step();
        checks++; if (bus.fill_done_o !== 1'b0) begin fails++; $display("[TB] FAIL fill_done_early2: got %b expected 0", bus.fill_done_o); end
        drive_beat(9, 0, 3, 8'h44);
        issue_read(9);
        step();
        idle_inputs();
        got = bus.rd_data_o;
        exp = exp_q.pop_front();
        checks++; if (bus.fill_done_o !== 1'b1 || bus.ready_o !== 1'b1 || bus.fill_beat_ready_o !== 1'b0) begin fails++; $display("[TB] FAIL fill_exit: got done=%b ready=%b beat_ready=%b expected 1 1 0", bus.fill_done_o, bus.ready_o, bus.fill_beat_ready_o); end
        checks++; if (got !== exp) begin fails++; $display("[TB] FAIL fill_bypass: got %h expected %h", got, exp); end
        checks++; if (got[0 +: LINE_BITS] !== {{8{8'h44}}, {8{8'h33}}, {8{8'h22}}, {8{8'h11}}}) begin fails++; $display("[TB] FAIL fill_order: got %h", got[0 +: LINE_BITS]); end
        step();
        checks++; if (bus.fill_done_o !== 1'b0) begin fails++; $display("[TB] FAIL fill_done_pulse: got %b expected 0", bus.fill_done_o); end
        issue_read(7);
        step();
        got = bus.rd_data_o;
        exp = exp_q.pop_front();
        checks++; if (got !== exp) begin fails++; $display("[TB] FAIL write_in_fill_ignored: got %h expected %h", got, exp); end
        issue_read(2);
        step();
        idle_inputs();
        got = bus.rd_data_o;
        exp = exp_q.pop_front();
        checks++; if (got !== exp) begin fails++; $display("[TB] FAIL write_with_fill_start: got %h expected %h", got, exp); end
    endtask

    task automatic test_reset_mid_fill();
        int cycles;
        bit done_seen, valid_seen;
        logic [DATA_W-1:0] got, exp;
        bus.fill_start_i = 1'b1;
        bus.fill_index_i = 4'd9;
        bus.fill_way_i   = 1'b0;
        step();
        idle_inputs();
        drive_beat(9, 0, 0, 8'h77);
        step();
        drive_beat(9, 0, 1, 8'h88);
        step();
        idle_inputs();
        rst_n = 1'b0;
        step();
        step();
        checks++; if (bus.fill_done_o !== 1'b0 || bus.ready_o !== 1'b0) begin fails++; $display("[TB] FAIL abort_in_reset: got done=%b ready=%b expected 0 0", bus.fill_done_o, bus.ready_o); end
        model_clear();
        rst_n = 1'b1;
        bus.rd_req_i   = 1'b1;
        bus.rd_index_i = 4'd9;
        bus.wr_req_i   = 1'b1;
        bus.wr_index_i = 4'd9;
        bus.wr_way_i   = 1'b0;
        bus.wr_be_i    = '1;
        bus.wr_data_i  = '1;
        cycles = 0;
        done_seen = 1'b0;
        valid_seen = 1'b0;
        while (bus.ready_o !== 1'b1 && cycles < 64) begin
            step();
            cycles++;
            if (bus.fill_done_o === 1'b1) done_seen = 1'b1;
            if (bus.rd_valid_o === 1'b1) valid_seen = 1'b1;
        end
        idle_inputs();
        checks++; if (cycles != SETS) begin fails++; $display("[TB] FAIL reinit_length: got %0d cycles expected %0d", cycles, SETS); end
        checks++; if (done_seen || valid_seen) begin fails++; $display("[TB] FAIL init_outputs: got done=%b valid=%b expected 0 0", done_seen, valid_seen); end
        issue_read(9);
        step();
        idle_inputs();
        got = bus.rd_data_o;
        exp = exp_q.pop_front();
        checks++; if (got !== exp) begin fails++; $display("[TB] FAIL reinit_set9: got %h expected %h", got, exp); end
        checks++; if (got !== '0) begin fails++; $display("[TB] FAIL reinit_zero: got %h expected 0", got); end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_write_read();
        test_bypass();
        test_fill();
        test_reset_mid_fill();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
